// File: rtl/sram_resp_pkg.sv
// Shared definitions for the SRAM-style responder bank.
//   state_t    : controller FSM encoding (ST_INIT zero-fills, ST_READY serves).
//   rd_src_t   : which registered source drives sram_rdata.
//   WEN_READ   : byte-enable pattern that marks a read.
//   merge()    : byte-lane merge of new write data into an old word.
package sram_resp_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SRC_ZERO  = 2'd0,
    SRC_ARRAY = 2'd1,
    SRC_CNT   = 2'd2
  } rd_src_t;

  localparam logic [3:0] WEN_READ = 4'b0000;

  // Byte i of the result comes from wdata when wen[i] is set, else from old.
  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] wdata,
                                        input logic [3:0]  wen);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (wen[i]) r[8*i +: 8] = wdata[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_resp_array.sv
// DEPTH x 32-bit word store with a single port.
// Ports:
//   clk   in   clock
//   we    in   4  byte write enables (0000 = no write)
//   re    in   1  read strobe; rdata is loaded only when re=1
//   idx   in   AW word index shared by read and write
//   wdata in   32 write data
//   rdata out  32 registered read data (holds while re=0)
module sram_resp_array
  import sram_resp_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic          re,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we != WEN_READ) mem[idx] <= merge(mem[idx], wdata, we);
    if (re)             rdata    <= mem[idx];
  end

endmodule

// File: rtl/sram_resp_bank_ctrl.sv
// Memory-side responder for one CPU SRAM-style port (instruction or data).
// Word reads return with a fixed 1-cycle latency; writes are byte-enabled.
// After reset the array is zero-filled one word per cycle (ST_INIT), then
// accesses are served (ST_READY). One MMIO word at CNT_ADDR exposes a
// free-running cycle counter; writing it clears the counter.
//
// Handshake: there is no ready/stall. A read presented with sram_en=1 and
// sram_wen=0 at a clock edge is answered on sram_rdata right after that edge
// and held until the next read (or access during init, or reset).
//
// Optional feature: define SRAM_RESP_STATS_EN to add saturating rd_cnt,
// wr_cnt and bad_cnt outputs.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   sram_en    in   access request
//   sram_wen   in   4  byte write enables, 0000 = read
//   sram_addr  in   32 byte address (bits [1:0] ignored)
//   sram_wdata in   32 write data
//   sram_rdata out  32 read data, one cycle after the request
//   init_done  out  zero-fill complete
//   err        out  sticky error (bad address or access during init)
//   rd_cnt/wr_cnt/bad_cnt out 32 (SRAM_RESP_STATS_EN only)
module sram_resp_bank_ctrl
  import sram_resp_pkg::*;
#(
  parameter logic [31:0] BASE     = 32'h0000_0000,
  parameter int          DEPTH    = 1024,
  parameter int          AW       = 10,
  parameter logic [31:0] CNT_ADDR = 32'h1FAF_F000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sram_en,
  input  logic [3:0]  sram_wen,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic        init_done,
  output logic        err
`ifdef SRAM_RESP_STATS_EN
  ,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt,
  output logic [31:0] bad_cnt
`endif
);

  state_t        state;
  rd_src_t       rd_src;
  logic [AW-1:0] fill_idx;
  logic [31:0]   cycle_cnt;
  logic [31:0]   cnt_snap;

  // Address decode. Unsigned subtraction makes addresses below BASE wrap
  // to a huge offset, so they naturally fall outside the window.
  logic [31:0]   off;
  logic          in_win;
  logic          is_cnt;
  logic          is_rd;
  logic [AW-1:0] win_idx;

  assign off     = sram_addr - BASE;
  assign in_win  = {2'b00, off[31:2]} < 32'(DEPTH);
  assign win_idx = off[AW+1:2];
  assign is_cnt  = sram_addr[31:2] == CNT_ADDR[31:2];
  assign is_rd   = sram_wen == WEN_READ;

  logic acc;     // request seen while serving
  logic acc_rd;  // accepted read (array or counter)
  logic acc_wr;  // accepted write (array or counter clear)
  logic bad;     // any err-setting access

  assign acc    = sram_en && (state == ST_READY);
  assign acc_rd = acc && is_rd && (in_win || is_cnt);
  assign acc_wr = acc && !is_rd && (in_win || is_cnt);
  assign bad    = sram_en && ((state == ST_INIT) || (!in_win && !is_cnt));

  // Array port: the init fill owns the port while in ST_INIT.
  logic [3:0]    arr_we;
  logic          arr_re;
  logic [AW-1:0] arr_idx;
  logic [31:0]   arr_wdata;
  logic [31:0]   arr_rdata;

  always_comb begin
    arr_we    = 4'b0000;
    arr_re    = 1'b0;
    arr_idx   = win_idx;
    arr_wdata = sram_wdata;
    if (!rst) begin
      if (state == ST_INIT) begin
        arr_we    = 4'b1111;
        arr_idx   = fill_idx;
        arr_wdata = 32'h0;
      end else if (acc && in_win) begin
        arr_we = is_rd ? 4'b0000 : sram_wen;
        arr_re = is_rd;
      end
    end
  end

  sram_resp_array #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .re   (arr_re),
    .idx  (arr_idx),
    .wdata(arr_wdata),
    .rdata(arr_rdata)
  );

  // Controller FSM, MMIO counter, read-source select and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      fill_idx  <= '0;
      init_done <= 1'b0;
      err       <= 1'b0;
      cycle_cnt <= 32'h0;
      cnt_snap  <= 32'h0;
      rd_src    <= SRC_ZERO;
    end else begin
      cycle_cnt <= cycle_cnt + 32'h1;
      case (state)
        ST_INIT: begin
          fill_idx <= fill_idx + 1'b1;
          if (fill_idx == AW'(DEPTH - 1)) begin
            state     <= ST_READY;
            init_done <= 1'b1;
          end
          if (sram_en) rd_src <= SRC_ZERO;
        end
        ST_READY: begin
          if (sram_en) begin
            if (is_rd) begin
              if (in_win) begin
                rd_src <= SRC_ARRAY;
              end else if (is_cnt) begin
                rd_src   <= SRC_CNT;
                cnt_snap <= cycle_cnt;
              end else begin
                rd_src <= SRC_ZERO;
              end
            end else if (!in_win && is_cnt) begin
              // Clear wins over the increment above.
              cycle_cnt <= 32'h0;
            end
          end
        end
        default: state <= ST_INIT;
      endcase
      if (bad) err <= 1'b1;
    end
  end

  always_comb begin
    case (rd_src)
      SRC_ARRAY: sram_rdata = arr_rdata;
      SRC_CNT:   sram_rdata = cnt_snap;
      default:   sram_rdata = 32'h0;
    endcase
  end

`ifdef SRAM_RESP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt  <= 32'h0;
      wr_cnt  <= 32'h0;
      bad_cnt <= 32'h0;
    end else begin
      if (acc_rd && (rd_cnt  != 32'hFFFF_FFFF)) rd_cnt  <= rd_cnt  + 32'h1;
      if (acc_wr && (wr_cnt  != 32'hFFFF_FFFF)) wr_cnt  <= wr_cnt  + 32'h1;
      if (bad    && (bad_cnt != 32'hFFFF_FFFF)) bad_cnt <= bad_cnt + 32'h1;
    end
  end
`else
  logic unused_stats;
  assign unused_stats = acc_rd ^ acc_wr;
`endif

endmodule

// File: tb/tb_sram_resp_bank_ctrl.sv
// Self-checking bench for sram_resp_bank_ctrl (default parameters).
// A behavioural model tracks memory words, the cycle counter, the sticky
// error and the fill progress; every read response it predicts goes into
// exp_q, and a negedge monitor pops and compares against sram_rdata.
module tb_sram_resp_bank_ctrl;

  localparam logic [31:0] BASE     = 32'h0000_0000;
  localparam int          DEPTH    = 1024;
  localparam logic [31:0] CNT_ADDR = 32'h1FAF_F000;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        init_done;
  logic        err;
`ifdef SRAM_RESP_STATS_EN
  logic [31:0] rd_cnt, wr_cnt, bad_cnt;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sram_resp_bank_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .sram_en   (sram_en),
    .sram_wen  (sram_wen),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata),
    .init_done (init_done),
    .err       (err)
`ifdef SRAM_RESP_STATS_EN
    ,
    .rd_cnt    (rd_cnt),
    .wr_cnt    (wr_cnt),
    .bad_cnt   (bad_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_cnt;
  int          m_fill;
  logic        m_err;
  logic        m_live = 1'b0;
  logic        rd_vld = 1'b0;
  logic [31:0] exp_q[$];
  longint      m_rd, m_wr, m_bad;

  initial begin
    forever begin
      logic [31:0] offs, word, cnt_now;
      logic        ready, inwin, iscnt;
      @(posedge clk);
      rd_vld = 1'b0;
      if (rst) begin
        m_live = 1'b1;
        m_fill = 0;
        m_cnt  = 32'h0;
        m_err  = 1'b0;
        m_rd = 0; m_wr = 0; m_bad = 0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        exp_q.delete();
        exp_q.push_back(32'h0);
        rd_vld = 1'b1;
      end else begin
        ready   = (m_fill == DEPTH);
        cnt_now = m_cnt;
        m_cnt   = m_cnt + 32'h1;
        if (sram_en) begin
          offs  = sram_addr - BASE;
          word  = offs >> 2;
          inwin = word < DEPTH;
          iscnt = (sram_addr >> 2) == (CNT_ADDR >> 2);
          if (!ready) begin
            m_err = 1'b1; m_bad++;
            exp_q.push_back(32'h0);
            rd_vld = 1'b1;
          end else if (sram_wen == 4'b0000) begin
            rd_vld = 1'b1;
            if (inwin)      begin exp_q.push_back(m_mem[word]); m_rd++; end
            else if (iscnt) begin exp_q.push_back(cnt_now);     m_rd++; end
            else begin exp_q.push_back(32'h0); m_err = 1'b1; m_bad++; end
          end else begin
            if (inwin) begin
              for (int b = 0; b < 4; b++)
                if (sram_wen[b]) m_mem[word][8*b +: 8] = sram_wdata[8*b +: 8];
              m_wr++;
            end else if (iscnt) begin
              m_cnt = 32'h0; m_wr++;
            end else begin
              m_err = 1'b1; m_bad++;
            end
          end
        end
        if (m_fill < DEPTH) m_fill++;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [31:0] last_rd = 32'h0;

  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        if (rd_vld) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_underflow: got response %08h, expected none queued", sram_rdata);
          end else begin
            last_rd = exp_q.pop_front();
          end
        end
        check32("rdata", sram_rdata, last_rd);
        check32("err", {31'h0, err}, {31'h0, m_err});
        check32("init_done", {31'h0, init_done}, {31'h0, (m_fill == DEPTH)});
`ifdef SRAM_RESP_STATS_EN
        check32("rd_cnt",  rd_cnt,  m_rd[31:0]);
        check32("wr_cnt",  wr_cnt,  m_wr[31:0]);
        check32("bad_cnt", bad_cnt, m_bad[31:0]);
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    sram_en    = e;
    sram_wen   = w;
    sram_addr  = a;
    sram_wdata = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic wait_init(input string name);
    int k;
    k = 0;
    sram_en = 1'b0;
    while (k < 2000) begin
      @(negedge clk);
      k++;
      if (init_done) break;
    end
    check32(name, k, DEPTH);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; sram_en = 1'b0; sram_wen = 4'h0; sram_addr = 32'h0; sram_wdata = 32'h0;
    @(negedge clk); @(negedge clk);
    check32("reset_rdata", sram_rdata, 32'h0);
    check32("reset_err", {31'h0, err}, 32'h0);
    check32("reset_init_done", {31'h0, init_done}, 32'h0);

    // Partial fill with one access during init, then reset mid-fill.
    rst = 1'b0;
    idle(99);
    drive(1'b1, 4'h0, BASE + 32'h20, 32'h0);
    idle(1);
    check32("init_access_rdata", sram_rdata, 32'h0);
    check32("init_access_err", {31'h0, err}, 32'h1);
    idle(399);
    check32("mid_init_done_low", {31'h0, init_done}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check32("rereset_err", {31'h0, err}, 32'h0);
    rst = 1'b0;
    wait_init("init_cycles");

    // Fill result.
    drive(1'b1, 4'h0, BASE + 32'h10, 32'h0);
    idle(1);
    check32("init_zero_read", sram_rdata, 32'h0);

    // Byte-enabled write, then read and hold for three idle cycles.
    drive(1'b1, 4'hF, BASE + 32'h8, 32'hAABB_CCDD);
    drive(1'b1, 4'h5, BASE + 32'h8, 32'h1122_3344);
    drive(1'b1, 4'h0, BASE + 32'h8, 32'h0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check32("byte_merge_hold", sram_rdata, 32'hAA22_CC44);
    end

    // Out-of-window read and write.
    drive(1'b1, 4'h0, BASE + DEPTH * 4, 32'h0);
    idle(1);
    check32("oob_read_rdata", sram_rdata, 32'h0);
    check32("oob_read_err", {31'h0, err}, 32'h1);
    drive(1'b1, 4'hF, BASE - 32'h4, 32'hFFFF_FFFF);
    drive(1'b1, 4'h0, BASE + ((DEPTH - 1) * 4), 32'h0);
    idle(1);
    check32("oob_write_dropped", sram_rdata, 32'h0);

    // Counter clear, five idle cycles, then read.
    drive(1'b1, 4'hF, CNT_ADDR, 32'hDEAD_BEEF);
    idle(5);
    drive(1'b1, 4'h0, CNT_ADDR, 32'h0);
    idle(1);
    check32("cnt_after_clear", sram_rdata, 32'h5);

    // Randomized traffic.
    for (int t = 0; t < 3000; t++) begin
      logic [31:0] a;
      logic [3:0]  w;
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: a = BASE + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
        5:             a = BASE + ($urandom_range(DEPTH - 4, DEPTH - 1) << 2);
        6:             a = CNT_ADDR + $urandom_range(0, 3);
        7:             a = BASE + DEPTH * 4 + ($urandom_range(0, 255) << 2);
        8:             a = BASE - 32'h4;
        default:       a = $urandom;
      endcase
      w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      drive(($urandom_range(0, 3) != 0), w, a, $urandom);
    end
    idle(3);
    check32("err_sticky_end", {31'h0, err}, 32'h1);
    check32("exp_q_drained", exp_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
